// File: rtl/l1_trig_pkg.sv
// Shared definitions for the L1 trigger scaler: stream beat layout and dump FSM states.
package l1_trig_pkg;

  localparam int SCAL_IDX_LSB = 24;
  localparam int SCAL_IDX_W   = 8;
  localparam int SCAL_CNT_W   = 24;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } scal_state_e;

endpackage

// File: rtl/l1_beam_holdoff_counter.sv
// One beam: deadtime holdoff, registered accept output and saturating accept count.
module l1_beam_holdoff_counter #(
  parameter int COUNT_BITS   = 24,
  parameter int HOLDOFF_BITS = 8
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    enable_i,
  input  logic                    terminal_i,
  input  logic                    trig_i,
  input  logic [HOLDOFF_BITS-1:0] holdoff_i,
  output logic                    accept_o,
  output logic [COUNT_BITS-1:0]   snap_o
);

  localparam logic [COUNT_BITS-1:0] CNT_MAX = '1;

  logic [HOLDOFF_BITS-1:0] hold_q, hold_d;
  logic [COUNT_BITS-1:0]   cnt_q, cnt_d, cnt_inc;
  logic                    accept_q, accept_d;

  always_comb begin
    accept_d = trig_i && (hold_q == '0);

    hold_d = hold_q;
    if (accept_d) begin
      hold_d = holdoff_i;
    end else if (hold_q != '0) begin
      hold_d = hold_q - HOLDOFF_BITS'(1);
    end

    // cnt_inc already includes this cycle's accept, so the terminal snapshot never loses it
    cnt_inc = cnt_q;
    if (accept_d && (cnt_q != CNT_MAX)) begin
      cnt_inc = cnt_q + COUNT_BITS'(1);
    end

    cnt_d = cnt_inc;
    if (!enable_i || terminal_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      hold_q   <= '0;
      cnt_q    <= '0;
      accept_q <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      cnt_q    <= cnt_d;
      accept_q <= accept_d;
    end
  end

  assign accept_o = accept_q;
  assign snap_o   = cnt_inc;

endmodule

// File: rtl/l1_trigger_scaler.sv
// Per-beam holdoff and rate scaler; dumps per-gate counts as an AXI4-Stream burst.
module l1_trigger_scaler
  import l1_trig_pkg::*;
#(
  parameter int NBEAMS       = 2,
  parameter int COUNT_BITS   = 24,
  parameter int HOLDOFF_BITS = 8,
  parameter int GATE_CYCLES  = 375000
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    enable_i,
  input  logic [HOLDOFF_BITS-1:0] holdoff_i,
  input  logic [NBEAMS-1:0]       trig_i,
  output logic [NBEAMS-1:0]       trig_o,
  output logic [31:0]             scal_tdata,
  output logic                    scal_tvalid,
  input  logic                    scal_tready,
  output logic                    scal_tlast,
  output logic                    missed_o
);

  localparam int IDX_W  = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;
  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NBEAMS - 1);

  logic [GATE_W-1:0]     gate_q, gate_d;
  logic                  terminal;
  scal_state_e           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  missed_q, missed_d;
  logic                  snap_en;
  logic [COUNT_BITS-1:0] snap     [NBEAMS];
  logic [COUNT_BITS-1:0] shadow_q [NBEAMS];

  generate
    for (genvar gi = 0; gi < NBEAMS; gi++) begin : g_beam
      l1_beam_holdoff_counter #(
        .COUNT_BITS   (COUNT_BITS),
        .HOLDOFF_BITS (HOLDOFF_BITS)
      ) u_beam (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .enable_i   (enable_i),
        .terminal_i (terminal),
        .trig_i     (trig_i[gi]),
        .holdoff_i  (holdoff_i),
        .accept_o   (trig_o[gi]),
        .snap_o     (snap[gi])
      );

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          shadow_q[gi] <= '0;
        end else if (snap_en) begin
          shadow_q[gi] <= snap[gi];
        end
      end
    end
  endgenerate

  // Gate counter restarts at 0 whenever enable_i is low, so the first gate is full length
  always_comb begin
    terminal = enable_i && (gate_q == GATE_LAST);
    gate_d   = gate_q + GATE_W'(1);
    if (!enable_i || terminal) begin
      gate_d = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    missed_d    = 1'b0;
    snap_en     = 1'b0;
    scal_tvalid = 1'b0;
    case (state_q)
      IDLE: begin
        if (terminal) begin
          snap_en = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        scal_tvalid = 1'b1;
        // A gate ending while a dump is in flight is dropped; the dump itself is untouched
        missed_d    = terminal;
        if (scal_tready) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    scal_tdata = '0;
    scal_tlast = 1'b0;
    if (state_q == SEND) begin
      scal_tdata[SCAL_IDX_LSB +: SCAL_IDX_W] = SCAL_IDX_W'(idx_q);
      scal_tdata[0 +: SCAL_CNT_W]            = SCAL_CNT_W'(shadow_q[idx_q]);
      scal_tlast                             = (idx_q == IDX_LAST);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      gate_q   <= '0;
      state_q  <= IDLE;
      idx_q    <= '0;
      missed_q <= 1'b0;
    end else begin
      gate_q   <= gate_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      missed_q <= missed_d;
    end
  end

  assign missed_o = missed_q;

endmodule

// File: tb/tb_l1_trigger_scaler.sv
// Directed bench for l1_trigger_scaler: holdoff, counting, stream dump, backpressure, reset.
module tb_l1_trigger_scaler;

  localparam int NBEAMS       = 2;
  localparam int COUNT_BITS   = 4;
  localparam int HOLDOFF_BITS = 8;
  localparam int GATE_CYCLES  = 16;

  logic                    aclk;
  logic                    aresetn;
  logic                    enable_i;
  logic [HOLDOFF_BITS-1:0] holdoff_i;
  logic [NBEAMS-1:0]       trig_i;
  logic [NBEAMS-1:0]       trig_o;
  logic [31:0]             scal_tdata;
  logic                    scal_tvalid;
  logic                    scal_tready;
  logic                    scal_tlast;
  logic                    missed_o;

  int total;
  int bad;

  l1_trigger_scaler #(
    .NBEAMS       (NBEAMS),
    .COUNT_BITS   (COUNT_BITS),
    .HOLDOFF_BITS (HOLDOFF_BITS),
    .GATE_CYCLES  (GATE_CYCLES)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .enable_i    (enable_i),
    .holdoff_i   (holdoff_i),
    .trig_i      (trig_i),
    .trig_o      (trig_o),
    .scal_tdata  (scal_tdata),
    .scal_tvalid (scal_tvalid),
    .scal_tready (scal_tready),
    .scal_tlast  (scal_tlast),
    .missed_o    (missed_o)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end else begin
      $display("ok   %s obs=%h", tag, obs);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  logic [7:0] pat;

  initial begin
    total       = 0;
    bad         = 0;
    aresetn     = 1'b0;
    enable_i    = 1'b0;
    holdoff_i   = 8'd3;
    trig_i      = '0;
    scal_tready = 1'b1;
    pat         = 8'b0110_1101;

    #12;
    chk("rst_trig",   32'(trig_o),      32'h0);
    chk("rst_tvalid", 32'(scal_tvalid), 32'h0);
    chk("rst_tlast",  32'(scal_tlast),  32'h0);
    chk("rst_tdata",  scal_tdata,       32'h0);
    chk("rst_missed", 32'(missed_o),    32'h0);
    tick();
    aresetn = 1'b1;

    // holdoff 3: accepts on cycles 0,4,8 appear on trig_o one cycle later
    for (int i = 0; i < 14; i++) begin
      trig_i[0] = (i < 12);
      tick();
      chk($sformatf("hold3_c%0d", i), 32'(trig_o[0]), 32'((i < 12) && (i % 4 == 0)));
    end

    holdoff_i = 8'd0;
    for (int i = 0; i < 8; i++) begin
      trig_i[0] = pat[i];
      tick();
      chk($sformatf("hold0_c%0d", i), 32'(trig_o[0]), 32'(pat[i]));
    end
    trig_i = '0;
    tick();

    // gate 1: beam0 accepts 5 times, last one on the terminal cycle; beam1 none
    for (int g = 0; g < GATE_CYCLES; g++) begin
      enable_i  = 1'b1;
      trig_i[0] = (g == 2 || g == 4 || g == 7 || g == 9 || g == 15);
      trig_i[1] = 1'b0;
      tick();
      if (g == 14) chk("g1_pre_tvalid", 32'(scal_tvalid), 32'h0);
    end
    chk("g1_b0_tvalid", 32'(scal_tvalid), 32'h1);
    chk("g1_b0_tdata",  scal_tdata,       32'h0000_0005);
    chk("g1_b0_tlast",  32'(scal_tlast),  32'h0);
    chk("g1_missed",    32'(missed_o),    32'h0);

    // gate 2: beam0 accepts only on T+1, beam1 saturates
    for (int g = 0; g < GATE_CYCLES; g++) begin
      trig_i[0] = (g == 0);
      trig_i[1] = 1'b1;
      tick();
      if (g == 0) begin
        chk("g1_b1_tdata", scal_tdata,      32'h0100_0000);
        chk("g1_b1_tlast", 32'(scal_tlast), 32'h1);
      end
      if (g == 1) chk("g1_end_tvalid", 32'(scal_tvalid), 32'h0);
    end
    chk("g2_b0_tvalid", 32'(scal_tvalid), 32'h1);
    chk("g2_b0_tdata",  scal_tdata,       32'h0000_0001);

    // backpressure for 20 cycles across the gate-3 terminal cycle
    scal_tready = 1'b0;
    for (int g = 0; g < GATE_CYCLES; g++) begin
      trig_i = 2'b11;
      tick();
      chk($sformatf("stall3_data_c%0d", g), scal_tdata, 32'h0000_0001);
      chk($sformatf("stall3_last_c%0d", g), 32'(scal_tlast), 32'h0);
      chk($sformatf("stall3_miss_c%0d", g), 32'(missed_o), 32'(g == 15));
    end
    for (int g = 0; g < GATE_CYCLES; g++) begin
      scal_tready = (g >= 4);
      trig_i[0]   = (g == 15);
      trig_i[1]   = 1'b0;
      tick();
      if (g < 4) begin
        chk($sformatf("stall4_data_c%0d", g), scal_tdata, 32'h0000_0001);
        chk($sformatf("stall4_miss_c%0d", g), 32'(missed_o), 32'h0);
      end
      if (g == 4) begin
        chk("g2_b1_tdata", scal_tdata,      32'h0100_000F);
        chk("g2_b1_tlast", 32'(scal_tlast), 32'h1);
      end
      if (g == 5) chk("g2_end_tvalid", 32'(scal_tvalid), 32'h0);
    end
    chk("g4_b0_tvalid", 32'(scal_tvalid), 32'h1);
    chk("g4_b0_tdata",  scal_tdata,       32'h0000_0001);
    chk("g4_trig_o",    32'(trig_o),      32'h1);

    // asynchronous reset in the middle of a dump
    #2;
    aresetn = 1'b0;
    trig_i  = '0;
    #1;
    chk("arst_trig",   32'(trig_o),      32'h0);
    chk("arst_tvalid", 32'(scal_tvalid), 32'h0);
    chk("arst_tlast",  32'(scal_tlast),  32'h0);
    chk("arst_tdata",  scal_tdata,       32'h0);
    chk("arst_missed", 32'(missed_o),    32'h0);
    tick();
    aresetn = 1'b1;

    for (int g = 0; g < GATE_CYCLES; g++) begin
      trig_i[0] = 1'b0;
      trig_i[1] = (g == 1 || g == 5 || g == 6);
      tick();
      if (g == 14) chk("post_pre_tvalid", 32'(scal_tvalid), 32'h0);
    end
    trig_i = '0;
    chk("post_b0_tvalid", 32'(scal_tvalid), 32'h1);
    chk("post_b0_tdata",  scal_tdata,       32'h0000_0000);
    tick();
    chk("post_b1_tdata",  scal_tdata,       32'h0100_0003);
    chk("post_b1_tlast",  32'(scal_tlast),  32'h1);
    tick();
    chk("post_end_tvalid", 32'(scal_tvalid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
